simple_c_monitor: RTL and testbench

SIMPLE_C_MONITOR -- requirements
Module: simple_c_monitor

---
 rtl/simple_c_monitor_pkg.sv | 30 +++
 rtl/simple_c_monitor_sat_counter.sv | 23 ++
 rtl/simple_c_monitor.sv | 148 ++++++++++++++
 tb/tb_simple_c_monitor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/simple_c_monitor_pkg.sv
// Shared definitions for the simple_c_monitor gate-network checker.
//   state_t            : monitor FSM state encoding
//   SETTLE_CYC_DEFAULT : default settle time in clock cycles
//   FF_*               : bit positions of each signal inside first_fail
//   expected_de        : reference model of the gate network, returns {d, e}
package simple_c_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    CHECK    = 2'd2,
    WAIT_CHG = 2'd3
  } state_t;

  localparam int unsigned SETTLE_CYC_DEFAULT = 6;

  // first_fail = {a, b, c, d, e}
  localparam int unsigned FF_W = 5;
  localparam int unsigned FF_A = 4;
  localparam int unsigned FF_B = 3;
  localparam int unsigned FF_C = 2;
  localparam int unsigned FF_D = 1;
  localparam int unsigned FF_E = 0;

  // abc = {a, b, c}; result = {exp_d, exp_e}
  function automatic logic [1:0] expected_de(input logic [2:0] abc);
    return {(abc[2] & abc[1]) | ~abc[0], ~abc[0]};
  endfunction

endpackage

// File: rtl/simple_c_monitor_sat_counter.sv
// Saturating up-counter used for both the check and the error counters.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears count
//   inc   : increment request for this cycle
//   count : current value, sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/simple_c_monitor.sv
// Monitor for a small combinational gate network (d = (a&b)|~c, e = ~c).
// After each change of {a,b,c} it waits SETTLE_CYC stable cycles, compares
// d/e once against the reference model, and accumulates statistics.
//   clk, rst      : clock and synchronous active-high reset
//   en            : enable; low returns the monitor to IDLE (statistics held)
//   a, b, c       : stimulus applied to the network
//   d, e          : observed network outputs
//   busy          : high in SETTLE or CHECK
//   chk_valid     : one-cycle pulse per comparison
//   chk_pass      : result of the most recent comparison
//   chk_count     : saturating number of comparisons
//   err_count     : saturating number of failed comparisons
//   fail_seen     : sticky, set by the first failure
//   first_fail    : {a,b,c,d,e} captured at the first failure
module simple_c_monitor
  import simple_c_monitor_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEFAULT,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  output logic             busy,
  output logic             chk_valid,
  output logic             chk_pass,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_seen,
  output logic [FF_W-1:0]  first_fail
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  state_t          state_q, state_d;
  logic [7:0]      settle_cnt_q, settle_cnt_d;
  logic [2:0]      vec_in, vec_q;
  logic            change;
  logic            chg_pend_q;
  logic            do_check;
  logic            pass;
  logic            err_inc;
  logic [FF_W-1:0] first_fail_d;

  assign vec_in  = {a, b, c};
  assign change  = (vec_in != vec_q);
  assign pass    = ({d, e} == expected_de(vec_q));
  assign err_inc = do_check & ~pass;
  assign busy    = (state_q == SETTLE) || (state_q == CHECK);

  always_comb begin
    first_fail_d       = '0;
    first_fail_d[FF_A] = vec_q[2];
    first_fail_d[FF_B] = vec_q[1];
    first_fail_d[FF_C] = vec_q[0];
    first_fail_d[FF_D] = d;
    first_fail_d[FF_E] = e;
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    do_check     = 1'b0;
    if (!en) begin
      state_d      = IDLE;
      settle_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = SETTLE;
          settle_cnt_d = '0;
        end
        SETTLE: begin
          if (change) begin
            settle_cnt_d = '0;
          end else if (settle_cnt_q == SETTLE_LAST) begin
            state_d      = CHECK;
            settle_cnt_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + 8'd1;
          end
        end
        CHECK: begin
          do_check = 1'b1;
          state_d  = WAIT_CHG;
        end
        WAIT_CHG: begin
          // vec_q already absorbed a change made during CHECK, so that
          // change is carried over in chg_pend_q rather than lost.
          if (change || chg_pend_q) begin
            state_d      = SETTLE;
            settle_cnt_d = '0;
          end
        end
        default: begin
          state_d      = IDLE;
          settle_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      vec_q        <= '0;
      chg_pend_q   <= 1'b0;
      chk_valid    <= 1'b0;
      chk_pass     <= 1'b0;
      fail_seen    <= 1'b0;
      first_fail   <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      vec_q        <= vec_in;
      chg_pend_q   <= do_check & change;
      chk_valid    <= do_check;
      if (do_check) begin
        chk_pass <= pass;
      end
      if (err_inc && !fail_seen) begin
        fail_seen  <= 1'b1;
        first_fail <= first_fail_d;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_chk_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (do_check),
    .count (chk_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .count (err_count)
  );

endmodule

// File: tb/tb_simple_c_monitor.sv
`timescale 1ns/1ps
module tb_simple_c_monitor;

  localparam int unsigned SETTLE_CYC = 6;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned SAT        = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic             a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0;
  logic             busy, chk_valid, chk_pass, fail_seen;
  logic [CNT_W-1:0] chk_count, err_count;
  logic [4:0]       first_fail;

  simple_c_monitor #(.SETTLE_CYC(SETTLE_CYC), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .e          (e),
    .busy       (busy),
    .chk_valid  (chk_valid),
    .chk_pass   (chk_pass),
    .chk_count  (chk_count),
    .err_count  (err_count),
    .fail_seen  (fail_seen),
    .first_fail (first_fail)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        pass;
    int unsigned chk;
    int unsigned err;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned m_chk   = 0;
  int unsigned m_err   = 0;
  logic        m_fail  = 1'b0;
  logic [4:0]  m_first = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic model_pass(input logic [2:0] v, input logic dd, input logic ee);
    return (dd == ((v[2] & v[1]) | ~v[0])) && (ee == ~v[0]);
  endfunction

  task automatic push(input logic [2:0] v, input logic dd, input logic ee, input int unsigned at);
    exp_t x;
    x.pass = model_pass(v, dd, ee);
    if (m_chk < SAT) m_chk++;
    if (!x.pass && m_err < SAT) m_err++;
    if (!x.pass && !m_fail) begin
      m_fail  = 1'b1;
      m_first = {v, dd, ee};
    end
    x.chk = m_chk;
    x.err = m_err;
    x.at  = at;
    sb.push_back(x);
  endtask

  task automatic drive(input logic [2:0] v, input logic dd, input logic ee);
    @(negedge clk);
    {a, b, c} = v;
    d = dd;
    e = ee;
  endtask

  task automatic apply(input logic [2:0] v, input logic dd, input logic ee);
    drive(v, dd, ee);
    push(v, dd, ee, cyc + SETTLE_CYC + 2);
    repeat (SETTLE_CYC + 3) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_chk_valid"},  chk_valid,  0);
    check({tag, "_chk_pass"},   chk_pass,   0);
    check({tag, "_chk_count"},  chk_count,  0);
    check({tag, "_err_count"},  err_count,  0);
    check({tag, "_fail_seen"},  fail_seen,  0);
    check({tag, "_first_fail"}, first_fail, 0);
  endtask

  // Monitor: every chk_valid pulse must match the oldest expected check.
  always @(negedge clk) begin : monitor
    exp_t x;
    if (chk_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_chk_valid: got pulse at cycle %0d, expected none", cyc);
      end else begin
        x = sb.pop_front();
        check("chk_pass",    chk_pass,  x.pass);
        check("chk_count",   chk_count, x.chk);
        check("err_count",   err_count, x.err);
        check("chk_latency", cyc,       x.at);
      end
    end
  end

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned t;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // First enable, all-zero vector, matching outputs
    @(negedge clk);
    en = 1'b1;
    {a, b, c} = 3'b000;
    d = 1'b1;
    e = 1'b1;
    push(3'b000, 1'b1, 1'b1, cyc + SETTLE_CYC + 2);
    @(negedge clk);
    check("busy_after_enable", busy, 1);
    repeat (SETTLE_CYC + 2) @(negedge clk);

    apply(3'b111, 1'b1, 1'b0);
    // short glitch through 011 so 111 is re-settled and re-checked with d=0
    drive(3'b011, 1'b0, 1'b0);
    apply(3'b111, 1'b0, 1'b0);
    check("fail_seen_set",   fail_seen,  1);
    check("first_fail_111",  first_fail, 5'b11100);

    // Toggle c every 3 cycles: settle never completes until it stops
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      c = ~c;
      if (i == 0) begin
        d = 1'b1;
        e = 1'b0;
      end
      t = cyc;
      repeat (2) @(negedge clk);
    end
    push(3'b111, 1'b1, 1'b0, t + SETTLE_CYC + 2);
    repeat (SETTLE_CYC + 1) @(negedge clk);

    // Input change landing in the CHECK cycle
    drive(3'b010, 1'b1, 1'b1);
    push(3'b010, 1'b1, 1'b1, cyc + SETTLE_CYC + 2);
    repeat (SETTLE_CYC + 1) @(negedge clk);
    {a, b, c} = 3'b100;
    push(3'b100, 1'b1, 1'b1, cyc + SETTLE_CYC + 3);
    repeat (SETTLE_CYC + 4) @(negedge clk);

    // Drop enable mid-SETTLE
    drive(3'b110, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("busy_in_settle", busy, 1);
    en = 1'b0;
    @(negedge clk);
    check("busy_after_en_drop", busy,      0);
    check("chk_count_held",     chk_count, m_chk);
    check("err_count_held",     err_count, m_err);
    repeat (10) @(negedge clk);
    check("chk_count_held_idle", chk_count, m_chk);
    en = 1'b1;
    push(3'b110, 1'b1, 1'b0, cyc + SETTLE_CYC + 2);
    repeat (SETTLE_CYC + 3) @(negedge clk);

    // Saturation with 300 failing vectors
    for (int i = 0; i < 150; i++) begin
      apply(3'b000, 1'b0, 1'b1);
      apply(3'b001, 1'b1, 1'b1);
    end
    check("chk_count_sat",   chk_count,  SAT);
    check("err_count_sat",   err_count,  SAT);
    check("fail_seen_held",  fail_seen,  1);
    check("first_fail_held", first_fail, m_first);

    // Reset during SETTLE
    drive(3'b011, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid_settle");
    @(negedge clk);
    check("chk_valid_after_rst", chk_valid, 0);
    rst    = 1'b0;
    m_chk  = 0;
    m_err  = 0;
    m_fail = 1'b0;
    push(3'b011, 1'b0, 1'b0, cyc + SETTLE_CYC + 2);
    repeat (SETTLE_CYC + 3) @(negedge clk);
    check("fail_seen_after_rst", fail_seen, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
